// File: rtl/recv_data_arbiter_pkg.sv
// Shared types, word-format constants and the word packing helper for the
// Nios receive-data arbiter.
package recv_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam int WORD_W    = 32;
    localparam int PAYLOAD_W = 27;
    localparam int SRC_W     = 3;
    localparam int VALID_BIT = 31;
    localparam int SEQ_BIT   = 30;
    localparam int SRC_LSB   = 27;

    function automatic logic [WORD_W-1:0] pack_word(
        input logic                 valid,
        input logic                 seq,
        input logic [SRC_W-1:0]     src,
        input logic [PAYLOAD_W-1:0] payload
    );
        return {valid, seq, src, payload};
    endfunction

endpackage

// File: rtl/recv_data_arbiter_rr.sv
// Round-robin winner select with a rotating priority pointer that advances
// past the winner whenever a grant is taken.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [2:0]   winner,
    output logic         any
);

    logic [2:0] rr_ptr_r;

    // Scans from the pointer upward with wrap; the lowest offset wins.
    function automatic logic [2:0] first_from(input logic [N-1:0] r, input logic [2:0] ptr);
        logic [2:0] w;
        int         idx;
        w = 3'd0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (r[idx]) begin
                w = 3'(idx);
            end
        end
        return w;
    endfunction

    // Combinational winner for the current request vector.
    always_comb begin
        any    = |req;
        winner = first_from(req, rr_ptr_r);
    end

    // Pointer moves to the requester after the one just granted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_r <= 3'd0;
        end else if (advance) begin
            rr_ptr_r <= (int'(winner) == N - 1) ? 3'd0 : winner + 3'd1;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

endmodule

// File: rtl/recv_data_arbiter.sv
// Shares the 32-bit Nios receive-data PIO between N_REQ producers.
// Optional word-drop timeout enabled by defining RECV_ARB_TIMEOUT_EN.
module recv_data_arbiter
    import recv_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int PAYLOAD_W   = 27,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*PAYLOAD_W-1:0] req_data,
    output logic [N_REQ-1:0]         req_ack,
    input  logic                     ack_toggle,
    output logic [31:0]              recv_word,
    output logic                     busy,
    output logic                     drop_flag,
    input  logic                     drop_clr
);

    state_t                 state_r;
    logic                   valid_r;
    logic                   seq_r;
    logic [SRC_W-1:0]       src_r;
    logic [PAYLOAD_W-1:0]   payload_r;
    logic [N_REQ-1:0]       req_ack_r;
    logic                   ack_prev_r;
    logic                   drop_flag_r;
    logic [2:0]             winner_s;
    logic                   any_s;
    logic                   grant_s;
    logic                   ack_evt_s;
    logic                   drop_evt_s;

    assign grant_s   = (state_r == IDLE) && any_s;
    assign ack_evt_s = (ack_toggle != ack_prev_r) && (state_r == PRESENT);

    rr_arbiter #(.N(N_REQ)) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_valid),
        .advance (grant_s),
        .winner  (winner_s),
        .any     (any_s)
    );

`ifdef RECV_ARB_TIMEOUT_EN
    logic [15:0] wait_cnt_r;

    assign drop_evt_s = (state_r == PRESENT) && !ack_evt_s &&
                        (wait_cnt_r == 16'(TIMEOUT_CYC - 1));

    // Counts PRESENT cycles; restarts on every new grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_r <= 16'd0;
        end else if (grant_s) begin
            wait_cnt_r <= 16'd0;
        end else if (state_r == PRESENT) begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end
`else
    assign drop_evt_s = 1'b0;
`endif

    // Hold FSM: grant in IDLE, hold in PRESENT until ack or timeout drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            valid_r    <= 1'b0;
            seq_r      <= 1'b0;
            src_r      <= '0;
            payload_r  <= '0;
            req_ack_r  <= '0;
            ack_prev_r <= 1'b0;
        end else begin
            ack_prev_r <= ack_toggle;
            req_ack_r  <= '0;
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        payload_r <= req_data[int'(winner_s)*PAYLOAD_W +: PAYLOAD_W];
                        src_r     <= winner_s;
                        seq_r     <= ~seq_r;
                        valid_r   <= 1'b1;
                        req_ack_r <= N_REQ'(1) << winner_s;
                        state_r   <= PRESENT;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                PRESENT: begin
                    // An ack in the drop cycle wins, so drop_evt_s already excludes it.
                    if (ack_evt_s || drop_evt_s) begin
                        valid_r <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= PRESENT;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Sticky drop indicator; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_flag_r <= 1'b0;
        end else if (drop_evt_s) begin
            drop_flag_r <= 1'b1;
        end else if (drop_clr) begin
            drop_flag_r <= 1'b0;
        end else begin
            drop_flag_r <= drop_flag_r;
        end
    end

    assign recv_word = pack_word(valid_r, seq_r, src_r, payload_r);
    assign req_ack   = req_ack_r;
    assign busy      = (state_r == PRESENT);
    assign drop_flag = drop_flag_r;

endmodule
